// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or
// auto-reload operation, masked interrupt request to the bridge.
module timer_dev (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state, state_nxt;
    logic        en, im, irqf;
    logic [1:0]  mode;
    logic [31:0] preset, count, count_nxt;
    logic        wr_ctrl, wr_preset, auto_mode;
    logic        hw_en_clr, irqf_set;

    assign wr_ctrl   = we && (addr == 2'b00);
    assign wr_preset = we && (addr == 2'b01);
    assign auto_mode = (mode == 2'b01);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        hw_en_clr = 1'b0;
        irqf_set  = 1'b0;
        case (state)
            IDLE: if (en) state_nxt = LOAD;
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (count == 32'd0) begin
                    state_nxt = INT;
                    irqf_set  = !auto_mode;
                end else begin
                    count_nxt = count - 32'd1;
                end
            end
            INT: begin
                if (auto_mode) begin
                    state_nxt = LOAD;
                end else begin
                    hw_en_clr = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= 32'd0;
            preset <= 32'd0;
            en     <= 1'b0;
            mode   <= 2'b00;
            im     <= 1'b0;
            irqf   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            // Software CTRL writes take priority over the one-shot EN self-clear.
            if (wr_ctrl) begin
                en   <= write_data[0];
                mode <= write_data[2:1];
                im   <= write_data[3];
            end else if (hw_en_clr) begin
                en <= 1'b0;
            end
            if (wr_preset) preset <= write_data;
            if (wr_ctrl || wr_preset) irqf <= 1'b0;
            else if (irqf_set)        irqf <= 1'b1;
        end
    end

    always_comb begin
        read_data = 32'd0;
        case (addr)
            2'b00:   read_data = {28'd0, im, mode, en};
            2'b01:   read_data = preset;
            2'b10:   read_data = count;
            default: read_data = 32'd0;
        endcase
    end

    assign irq = im && (irqf || (state == INT && auto_mode));

endmodule

// File: tb/tb_timer_dev.sv
// Randomized bench for timer_dev; expectations come from the cycle-position
// formulas of the timer's documented timing.
module tb_timer_dev;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  addr = 2'b00;
    logic        we = 1'b0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        irq;

    int errors = 0;
    int checks = 0;

    timer_dev dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .we(we),
        .write_data(write_data), .read_data(read_data), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; write_data = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = read_data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Position k = edges since the EN write. Period = LOAD, N+1 CNT cycles, INT.
    function automatic logic [31:0] exp_count(int n, bit auto_m, int k);
        int p;
        if (k < 2) return 32'd0;
        if (!auto_m && k >= n + 3) return 32'd0;
        p = (k - 1) % (n + 3);
        if (p == 0) return 32'd0;
        if (p <= n + 1) return 32'(n - (p - 1));
        return 32'd0;
    endfunction

    function automatic logic exp_irq(int n, bit auto_m, bit imv, int k);
        if (!imv) return 1'b0;
        if (auto_m) return ((k - 1) % (n + 3)) == n + 2;
        return k >= n + 3;
    endfunction

    task automatic run_timer(input int n, input logic [1:0] md, input logic imv);
        logic [31:0] v;
        bit          auto_m;
        int          cyc;
        logic        en_e;
        auto_m = (md == 2'b01);
        cyc = auto_m ? 3 * (n + 3) + 1 : n + 6;
        do_reset();
        wr(2'b01, 32'(n));
        wr(2'b00, {28'd0, imv, md, 1'b1});
        for (int k = 1; k <= cyc; k++) begin
            tick();
            en_e = auto_m ? 1'b1 : (k < n + 4);
            rd(2'b10, v);
            chk("count", v, exp_count(n, auto_m, k));
            rd(2'b00, v);
            chk("ctrl", v, {28'd0, imv, md, en_e});
            chk("irq", {31'd0, irq}, {31'd0, exp_irq(n, auto_m, imv, k)});
        end
        wr(2'b00, 32'd0);
        chk("irq_after_ctrl_clear", {31'd0, irq}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        #3;
        do_reset();
        chk("rst_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            chk("rst_read", v, 32'd0);
        end

        wr(2'b00, 32'hFFFF_FFFF);
        rd(2'b00, v);
        chk("ctrl_mask", v, 32'h0000_000F);
        wr(2'b00, 32'd0);
        wr(2'b10, 32'd5);
        rd(2'b10, v);
        chk("count_ro", v, 32'd0);
        wr(2'b11, 32'h1234_5678);
        rd(2'b11, v);
        chk("addr3_read", v, 32'd0);

        // Directed cases from the documented scenarios, then random ones.
        run_timer(5, 2'b00, 1'b1);
        run_timer(3, 2'b01, 1'b1);
        run_timer(4, 2'b00, 1'b0);
        run_timer(0, 2'b00, 1'b1);
        run_timer(0, 2'b01, 1'b1);
        for (int i = 0; i < 20; i++)
            run_timer(int'($urandom_range(0, 12)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        // Pause at COUNT=2, then re-enable reloads PRESET.
        do_reset();
        wr(2'b01, 32'd5);
        wr(2'b00, 32'h9);
        for (int k = 0; k < 4; k++) tick();
        rd(2'b10, v);
        chk("pause_pre", v, 32'd3);
        wr(2'b00, 32'h8);
        for (int k = 0; k < 3; k++) begin
            tick();
            rd(2'b10, v);
            chk("pause_hold", v, 32'd2);
            rd(2'b00, v);
            chk("pause_ctrl", v, 32'h8);
            chk("pause_irq", {31'd0, irq}, 32'd0);
        end
        wr(2'b00, 32'h9);
        tick();
        rd(2'b10, v);
        chk("reen_load", v, 32'd2);
        tick();
        rd(2'b10, v);
        chk("reen_count", v, 32'd5);

        // PRESET rewritten mid-count applies only at the next reload.
        do_reset();
        wr(2'b01, 32'd6);
        wr(2'b00, 32'hB);
        for (int k = 0; k < 3; k++) tick();
        rd(2'b10, v);
        chk("mid_pre", v, 32'd5);
        wr(2'b01, 32'd2);
        rd(2'b10, v);
        chk("mid_unaffected", v, 32'd4);
        for (int k = 5; k <= 9; k++) tick();
        chk("mid_int_irq", {31'd0, irq}, 32'd1);
        tick();
        chk("mid_load_irq", {31'd0, irq}, 32'd0);
        tick();
        rd(2'b10, v);
        chk("mid_reload", v, 32'd2);

        // Asynchronous reset mid-count.
        do_reset();
        wr(2'b01, 32'd9);
        wr(2'b00, 32'h9);
        for (int k = 0; k < 4; k++) tick();
        rd(2'b10, v);
        chk("arst_pre", v, 32'd7);
        rst_n = 1'b0;
        rd(2'b10, v);
        chk("arst_count", v, 32'd0);
        rd(2'b00, v);
        chk("arst_ctrl", v, 32'd0);
        rst_n = 1'b1;

        // Asynchronous reset with the one-shot irq held high.
        wr(2'b01, 32'd0);
        wr(2'b00, 32'h9);
        for (int k = 0; k < 4; k++) tick();
        chk("arst_irq_pre", {31'd0, irq}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_irq", {31'd0, irq}, 32'd0);
        rd(2'b00, v);
        chk("arst_ctrl2", v, 32'd0);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer sitting on device port 0 of the system bridge (word window 0x0000_7F00–0x0000_7F0B). It exposes three word registers (CTRL, PRESET, COUNT), selected by address bits [3:2]. It counts down from a software-loaded preset and raises an interrupt request that the bridge forwards as hardware interrupt line 0. Two modes are supported: one-shot (level interrupt, self-disabling) and auto-reload (periodic one-cycle interrupt pulse).

## Interface
- No parameters; all widths fixed at 32 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- addr  input  2 (bits [3:2])  register select: 00 CTRL, 01 PRESET, 10 COUNT, 11 unused.
- we  input  1  write enable from the bridge; already qualified by the device-0 address hit.
- write_data  input  32  write data.
- read_data  output  32  combinational read of the selected register.
- irq  output  1  interrupt request to the bridge.

## Operation
- CTRL fields:
  - [0] EN: enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload; 10 and 11 behave as 00 but read back as written.
  - [3] IM: interrupt mask, 1 = irq permitted.
  - [31:4] read 0; writes to them are discarded.
- PRESET: 32-bit read/write.
- COUNT: 32-bit, read-only; writes are ignored.
- Address 11: reads 0; writes are ignored.
- State machine with four states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, next state is LOAD; COUNT holds.
  - LOAD: COUNT <= PRESET; next state is CNT.
  - CNT:
    - If EN=0, next state is IDLE and COUNT holds its value.
    - Else if COUNT==0, next state is INT.
    - Else COUNT <= COUNT-1. Decrement is modulo 2^32, but it never wraps because zero is tested first.
  - INT, MODE 01: next state is LOAD (periodic reload).
  - INT, other modes: hardware clears EN; next state is IDLE.
- Interrupt flag (IRQF, internal):
  - Set on the edge entering INT when MODE≠01.
  - Cleared by any write to CTRL or PRESET, and by reset.
- irq = IM & (IRQF | (state==INT & MODE==01)).
- Simultaneous events:
  - A software write to CTRL in the INT cycle overrides the hardware EN clear.
  - The IRQF clear from a write wins over an IRQF set in the same cycle.
- A PRESET write during CNT does not affect the running count; it is used at the next LOAD.
- Clearing EN during LOAD or INT: the state sequence completes that state, then goes to IDLE on the next cycle seen with EN=0. In one-shot, INT still sets IRQF.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, IRQF=0, state=IDLE, irq=0. read_data shows CTRL (0) while addr=00.
- Register writes take effect at the clock edge where we=1. read_data reflects new contents after that edge.
- Cycle counting: the edge that writes EN=1 is edge 0, with PRESET=N already written.
  - edge 1: LOAD.
  - edge 2: COUNT=N, state CNT.
  - edges 3..N+2: decrements to 0.
  - edge N+3: enters INT; irq rises after edge N+3 when IM=1.
- One-shot:
  - Edge N+4: EN=0, state IDLE.
  - irq stays high until a CTRL or PRESET write.
- Auto-reload:
  - irq is high for exactly one cycle per period.
  - Period is N+3 cycles (LOAD, N+1 CNT cycles, INT).
  - COUNT reloads to N on the edge after INT.
- PRESET=0: CNT lasts 1 cycle. One-shot irq rises after edge 3; auto-reload period is 3 cycles.
- Reset asserted mid-count: all state returns to reset values immediately (asynchronously); irq drops without waiting for clk.

## Test plan
- Reset/readback:
  - Stimulus: after reset, read addr 00/01/10/11.
  - Response: all read 0.
  - Stimulus: write CTRL=0xFFFF_FFFF.
  - Response: CTRL reads 0x0000_000F.
  - Stimulus: write COUNT=5.
  - Response: COUNT still reads 0.
- One-shot:
  - Stimulus: PRESET=5, CTRL=0x9 (EN, IM, mode 00).
  - Response: COUNT=5 after edge 2 and reaches 0 after edge 7; irq rises after edge 8; CTRL reads 0x8 after edge 9; irq holds.
  - Stimulus: then write CTRL=0.
  - Response: irq drops after that edge.
- Auto-reload:
  - Stimulus: PRESET=3, CTRL=0xB.
  - Response: irq is a one-cycle pulse every 6 cycles, first after edge 6; COUNT reloads to 3; EN stays 1.
- Masking and pause:
  - Stimulus: one-shot with IM=0.
  - Response: irq stays 0; EN still self-clears.
  - Stimulus: clear EN mid-count at COUNT=2.
  - Response: COUNT holds 2 in IDLE; re-enabling reloads PRESET.
- Boundary:
  - Stimulus: PRESET=0, one-shot.
  - Response: irq after edge 3.
  - Stimulus: PRESET write during CNT.
  - Response: current count is unaffected; the new value is used at the next reload.
  - Stimulus: assert rst_n low mid-count with irq high.
  - Response: irq, COUNT and CTRL all go to 0 asynchronously.
